banco_registradores: RTL and testbench



---
 rtl/banco_registradores_pkg.sv | 17 +
 rtl/estagio_escrita.sv | 45 ++++
 rtl/banco_registradores.sv | 66 ++++++
 tb/tb_banco_registradores.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_pkg.sv
// Shared constants and helpers for the general-purpose register file.
package banco_registradores_pkg;

  localparam int unsigned LARGURA  = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned END_W    = 5;
  localparam int unsigned SP_IDX   = 29;
  localparam logic [LARGURA-1:0] SP_INIT = 32'h0000_03FF;

  localparam logic [END_W-1:0] REG_ZERO = '0;

  // Only meaningful when NUM_REGS < 2**END_W; otherwise every index is valid.
  function automatic logic endereco_valido(input logic [END_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

endpackage

// File: rtl/estagio_escrita.sv
// One-entry write staging register between the write-back mux and the register array.
module estagio_escrita
  import banco_registradores_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               escreve_reg,
  input  logic [END_W-1:0]   end_escrita,
  input  logic [LARGURA-1:0] dado_escrita,
  output logic               commit,
  output logic [END_W-1:0]   end_commit,
  output logic [LARGURA-1:0] dado_commit
);

  logic               valido_q;
  logic [END_W-1:0]   end_q;
  logic [LARGURA-1:0] dado_q;
  logic               captura;

  // Writes to the zero register or past the array are dropped here.
  always_comb begin
    captura = escreve_reg && (end_escrita != REG_ZERO) && endereco_valido(end_escrita);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valido_q <= 1'b0;
      end_q    <= '0;
      dado_q   <= '0;
    end else begin
      valido_q <= captura;
      if (captura) begin
        end_q  <= end_escrita;
        dado_q <= dado_escrita;
      end
    end
  end

  always_comb begin
    commit      = valido_q;
    end_commit  = end_q;
    dado_commit = dado_q;
  end

endmodule

// File: rtl/banco_registradores.sv
// Register file with staged writes; forwarding keeps write-to-read visibility at one edge.
module banco_registradores
  import banco_registradores_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               escreve_reg,
  input  logic [END_W-1:0]   end_escrita,
  input  logic [LARGURA-1:0] dado_escrita,
  input  logic [END_W-1:0]   end_leitura1,
  input  logic [END_W-1:0]   end_leitura2,
  output logic [LARGURA-1:0] dado_leitura1,
  output logic [LARGURA-1:0] dado_leitura2,
  input  logic [END_W-1:0]   end_debug,
  output logic [LARGURA-1:0] dado_debug,
  output logic               pendente
);

  logic [LARGURA-1:0] regs_q [NUM_REGS];
  logic               commit;
  logic [END_W-1:0]   end_commit;
  logic [LARGURA-1:0] dado_commit;

  estagio_escrita u_estagio (
    .clock        (clock),
    .reset        (reset),
    .escreve_reg  (escreve_reg),
    .end_escrita  (end_escrita),
    .dado_escrita (dado_escrita),
    .commit       (commit),
    .end_commit   (end_commit),
    .dado_commit  (dado_commit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (i == int'(SP_IDX)) ? SP_INIT : '0;
      end
    end else if (commit) begin
      regs_q[end_commit] <= dado_commit;
    end
  end

  // Staged entry overrides the array so a write is visible right after its capture edge.
  function automatic logic [LARGURA-1:0] ler_porta(input logic [END_W-1:0] a);
    logic [LARGURA-1:0] r;
    r = '0;
    if (a == REG_ZERO || !endereco_valido(a)) begin
      r = '0;
    end else if (commit && (a == end_commit)) begin
      r = dado_commit;
    end else begin
      r = regs_q[a];
    end
    return r;
  endfunction

  always_comb begin
    dado_leitura1 = ler_porta(end_leitura1);
    dado_leitura2 = ler_porta(end_leitura2);
    dado_debug    = ler_porta(end_debug);
    pendente      = commit;
  end

endmodule

// File: tb/tb_banco_registradores.sv
// Scoreboard bench: the driver queues expected reads, the monitor checks them each falling edge.
module tb_banco_registradores;
  import banco_registradores_pkg::*;

  logic               clock;
  logic               reset;
  logic               escreve_reg;
  logic [END_W-1:0]   end_escrita;
  logic [LARGURA-1:0] dado_escrita;
  logic [END_W-1:0]   end_leitura1;
  logic [END_W-1:0]   end_leitura2;
  logic [END_W-1:0]   end_debug;
  logic [LARGURA-1:0] dado_leitura1;
  logic [LARGURA-1:0] dado_leitura2;
  logic [LARGURA-1:0] dado_debug;
  logic               pendente;

  banco_registradores dut (
    .clock         (clock),
    .reset         (reset),
    .escreve_reg   (escreve_reg),
    .end_escrita   (end_escrita),
    .dado_escrita  (dado_escrita),
    .end_leitura1  (end_leitura1),
    .end_leitura2  (end_leitura2),
    .dado_leitura1 (dado_leitura1),
    .dado_leitura2 (dado_leitura2),
    .end_debug     (end_debug),
    .dado_debug    (dado_debug),
    .pendente      (pendente)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
    logic        ep;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: array state as seen by reads after the most recent edge.
  logic [31:0] m [32];
  logic        p_we;
  logic [4:0]  p_wa;
  logic [31:0] p_wd;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = (i == 29) ? 32'h0000_03FF : 32'h0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : m[a];
  endfunction

  task automatic chk(input string tag, input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", tag, nm, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, "rd1", dado_leitura1, e.e1);
      chk(e.tag, "rd2", dado_leitura2, e.e2);
      chk(e.tag, "dbg", dado_debug, e.ed);
      chk(e.tag, "pendente", {31'b0, pendente}, {31'b0, e.ep});
    end
  end

  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input bit rst, input string tag);
    exp_t e;
    logic ep;
    @(posedge clock);
    ep = 1'b0;
    if (p_we && p_wa != 5'd0) begin
      m[p_wa] = p_wd;
      ep = 1'b1;
    end
    #1;
    escreve_reg  = we;
    end_escrita  = wa;
    dado_escrita = wd;
    end_leitura1 = r1;
    end_leitura2 = r2;
    end_debug    = rd;
    p_we = we;
    p_wa = wa;
    p_wd = wd;
    if (rst) begin
      reset = 1'b0;
      model_reset();
      p_we = 1'b0;
      ep   = 1'b0;
    end
    e.tag = tag;
    e.e1  = exp_rd(r1);
    e.e2  = exp_rd(r2);
    e.ed  = exp_rd(rd);
    e.ep  = ep;
    q.push_back(e);
    if (rst) begin
      #6;
      reset = 1'b1;
    end
  endtask

  initial begin
    exp_t e;
    reset        = 1'b0;
    escreve_reg  = 1'b0;
    end_escrita  = '0;
    dado_escrita = '0;
    end_leitura1 = 5'd29;
    end_leitura2 = 5'd0;
    end_debug    = 5'd1;
    p_we = 1'b0;
    p_wa = '0;
    p_wd = '0;
    model_reset();
    e.tag = "in_reset";
    e.e1 = 32'h0000_03FF;
    e.e2 = 32'h0;
    e.ed = 32'h0;
    e.ep = 1'b0;
    q.push_back(e);
    #12 reset = 1'b1;

    // Reset contents on every index.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'((i + 1) % 32), 5'((i + 2) % 32), 1'b0, "reset_vals");
    end

    // Single write, staged then committed.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd29, 5'd5, 1'b0, "w5_before");
    step(1'b0, 5'd0, 32'h0,         5'd5, 5'd5,  5'd0, 1'b0, "w5_staged");
    step(1'b0, 5'd0, 32'h0,         5'd5, 5'd5,  5'd5, 1'b0, "w5_commit");

    // Zero register is never written.
    step(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0, 1'b0, "r0_req");
    step(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0, 1'b0, "r0_again");
    step(1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 5'd0, 1'b0, "r0_after");

    // Back-to-back writes, same and different addresses.
    step(1'b1, 5'd7, 32'h1, 5'd7, 5'd7, 5'd7, 1'b0, "w7a");
    step(1'b1, 5'd7, 32'h2, 5'd7, 5'd7, 5'd7, 1'b0, "w7b");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 1'b0, "w7_staged");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 5'd7, 1'b0, "w7_commit");
    step(1'b1, 5'd3, 32'hA, 5'd3, 5'd4, 5'd7, 1'b0, "w3");
    step(1'b1, 5'd4, 32'hB, 5'd3, 5'd4, 5'd0, 1'b0, "w4");
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd3, 1'b0, "w34_a");
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd4, 1'b0, "w34_b");

    // Reset between edges drops the staged write.
    step(1'b1, 5'd9, 32'h55, 5'd9, 5'd7, 5'd29, 1'b0, "w9_req");
    step(1'b0, 5'd0, 32'h0,  5'd9, 5'd7, 5'd3,  1'b1, "w9_reset");
    step(1'b0, 5'd0, 32'h0,  5'd9, 5'd5, 5'd29, 1'b0, "w9_after");
    step(1'b0, 5'd0, 32'h0,  5'd9, 5'd7, 5'd4,  1'b0, "w9_after2");

    // Randomized traffic against the model, biased toward address collisions.
    for (int k = 0; k < 1000; k++) begin
      logic [4:0] wa, r1, r2, rd;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 5));
      r2 = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 5));
      step(1'($urandom_range(0, 1)), wa, $urandom, r1, r2, rd, 1'b0, "random");
    end

    @(posedge clock);
    escreve_reg = 1'b0;
    @(negedge clock);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
